// File: rtl/sr_reg_dump_pkg.sv
// Shared types and constants for the debug register dump initiator.
package sr_dbg_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // The CPU returns the PC when debug address 0 is read.
  localparam logic [REG_ADDR_W-1:0] DBG_PC_IDX = '0;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND
  } state_e;

endpackage

// File: rtl/sr_reg_dump_if.sv
// Valid/ready beat stream carrying one dumped register per beat.
interface sr_reg_dump_if
  import sr_dbg_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);

  logic                  valid;
  logic                  ready;
  logic [DATA_W-1:0]     data;
  logic [REG_ADDR_W-1:0] index;
  logic                  last;

  modport master (output valid, data, index, last, input ready);
  modport slave  (input valid, data, index, last, output ready);

endinterface

// File: rtl/sr_reg_dump.sv
// Walks CPU debug register indices 0..NUM_REGS-1 and emits each sampled word
// as one stream beat; tracks the number of completed dumps.
module sr_reg_dump
  import sr_dbg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_auto_en,
  input  logic                  i_noop,
  input  logic                  i_abort,
  output logic [REG_ADDR_W-1:0] o_reg_addr,
  input  logic [DATA_W-1:0]     i_reg_data,
  sr_reg_dump_if.master         o_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_dump_count
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  state_e                r_state, w_state_nxt;
  logic [REG_ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [DATA_W-1:0]     r_data, w_data_nxt;
  logic [REG_ADDR_W-1:0] r_index, w_index_nxt;
  logic                  r_last, w_last_nxt;
  logic                  r_done, w_done_nxt;
  logic [CNT_W-1:0]      r_count, w_count_nxt;
  logic                  w_hs;

  assign w_hs = (r_state == SEND) && o_out.ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_idx   <= DBG_PC_IDX;
      r_data  <= '0;
      r_index <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_index <= w_index_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Abort outranks start and handshake; it is a no-op in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_index_nxt = r_index;
    w_last_nxt  = r_last;
    w_done_nxt  = 1'b0;
    w_count_nxt = r_count;
    unique case (r_state)
      IDLE: begin
        w_idx_nxt = DBG_PC_IDX;
        if (i_start || (i_auto_en && i_noop)) begin
          w_state_nxt = READ;
        end
      end
      READ: begin
        if (i_abort) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = DBG_PC_IDX;
        end else begin
          w_data_nxt  = i_reg_data;
          w_index_nxt = r_idx;
          w_last_nxt  = (r_idx == LAST_IDX);
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (i_abort) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = DBG_PC_IDX;
        end else if (w_hs) begin
          if (r_last) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = DBG_PC_IDX;
            w_done_nxt  = 1'b1;
            w_count_nxt = r_count + CNT_W'(1);
          end else begin
            w_state_nxt = READ;
            w_idx_nxt   = r_idx + REG_ADDR_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = DBG_PC_IDX;
      end
    endcase
  end

  always_comb begin
    o_reg_addr   = r_idx;
    o_out.valid  = (r_state == SEND);
    o_out.data   = r_data;
    o_out.index  = r_index;
    o_out.last   = r_last;
    o_busy       = (r_state != IDLE);
    o_done       = r_done;
    o_dump_count = r_count;
  end

endmodule

// File: tb/tb_sr_reg_dump.sv
// Directed-plus-random bench for sr_reg_dump with a queue-based beat scoreboard.
module tb_sr_reg_dump;
  import sr_dbg_pkg::*;

  localparam int unsigned NREG = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, auto_en, noop, abort, start1;
  logic [4:0]  reg_addr, reg_addr1;
  logic [31:0] reg_data, reg_data1, base, base1;
  logic        busy, done, busy1, done1;
  logic [15:0] dump_count, dump_count1;

  sr_reg_dump_if #(.DATA_W(32)) s_if ();
  sr_reg_dump_if #(.DATA_W(32)) s1_if ();

  // CPU model: register r reads as base + r, index 0 being the PC.
  assign reg_data  = base + 32'(reg_addr);
  assign reg_data1 = base1 + 32'(reg_addr1);

  sr_reg_dump #(.NUM_REGS(NREG), .DATA_W(32), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_auto_en(auto_en), .i_noop(noop),
    .i_abort(abort), .o_reg_addr(reg_addr), .i_reg_data(reg_data), .o_out(s_if),
    .o_busy(busy), .o_done(done), .o_dump_count(dump_count)
  );

  sr_reg_dump #(.NUM_REGS(1), .DATA_W(32), .CNT_W(16)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_auto_en(1'b0), .i_noop(1'b0),
    .i_abort(1'b0), .o_reg_addr(reg_addr1), .i_reg_data(reg_data1), .o_out(s1_if),
    .o_busy(busy1), .o_done(done1), .o_dump_count(dump_count1)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  index;
    logic        last;
  } beat_t;

  beat_t       beats[$];
  int          done_cnt = 0;
  int          viol = 0;
  logic        p_stall = 1'b0;
  logic [37:0] p_beat = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Monitor: collect accepted beats, count done pulses, flag unstable stalled beats.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (s_if.valid && s_if.ready && !abort) beats.push_back({s_if.data, s_if.index, s_if.last});
      if (done) done_cnt <= done_cnt + 1;
      if (p_stall && !(s_if.valid && ({s_if.data, s_if.index, s_if.last} == p_beat)))
        viol <= viol + 1;
      p_stall <= s_if.valid && !s_if.ready && !abort;
      p_beat  <= {s_if.data, s_if.index, s_if.last};
    end else begin
      p_stall <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input int mode, input logic [4:0] a);
    case (mode)
      0:       return (s_if.valid === 1'b1) && (s_if.index === a);
      1:       return (busy === 1'b1) && (s_if.valid === 1'b0) && (reg_addr === a);
      default: return done === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int mode, input logic [4:0] a, input int budget,
                          input string tag, output int cyc);
    cyc = 0;
    while (!hit(mode, a)) begin
      if (cyc >= budget) begin
        chk({tag, "_timeout"}, 64'd1, 64'd0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  // Expected stream: ndumps back-to-back dumps of indices 0..NREG-1, each reading base+index.
  task automatic check_dump(input string tag, input logic [31:0] b, input int ndumps);
    int bad;
    int r;
    bad = 0;
    chk({tag, "_nbeats"}, 64'(beats.size()), 64'(ndumps * NREG));
    foreach (beats[k]) begin
      r = k % NREG;
      if (beats[k].data !== b + 32'(r) || beats[k].index !== 5'(r) ||
          beats[k].last !== (r == NREG - 1)) bad++;
    end
    chk({tag, "_content"}, 64'(bad), 64'd0);
    beats.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    int bad;
    int saw;
    int k;
    rst = 1'b0; start = 1'b0; auto_en = 1'b0; noop = 1'b0; abort = 1'b0; start1 = 1'b0;
    s_if.ready = 1'b0; s1_if.ready = 1'b0;
    base = 32'h1000_0000; base1 = $urandom;
    repeat (3) @(negedge clk);

    chk("rst_addr", 64'(reg_addr), 0);
    chk("rst_valid", 64'(s_if.valid), 0);
    chk("rst_data", 64'(s_if.data), 0);
    chk("rst_index", 64'(s_if.index), 0);
    chk("rst_last", 64'(s_if.last), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_count", 64'(dump_count), 0);
    chk("rst1_valid", 64'(s1_if.valid), 0);
    chk("rst1_count", 64'(dump_count1), 0);

    rst = 1'b1; s_if.ready = 1'b1; s1_if.ready = 1'b1;

    // Full dump, ready held high
    pulse_start();
    chk("t1_busy", 64'(busy), 1);
    chk("t1_valid_early", 64'(s_if.valid), 0);
    @(negedge clk);
    chk("t1_valid_lat", 64'(s_if.valid), 1);
    chk("t1_first_idx", 64'(s_if.index), 0);
    chk("t1_first_pc", 64'(s_if.data), 64'h1000_0000);
    wait_for(2, 5'd0, 200, "t1_done", cyc);
    chk("t1_cycles", 64'(cyc + 2), 65);
    chk("t1_count", 64'(dump_count), 1);
    check_dump("t1", base, 1);
    @(negedge clk);
    chk("t1_done_width", 64'(done), 0);
    chk("t1_done_cnt", 64'(done_cnt), 1);

    // Backpressure on index 3, then random ready
    base = $urandom;
    pulse_start();
    wait_for(1, 5'd3, 100, "t2_w3", cyc);
    s_if.ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!(s_if.valid === 1'b1 && s_if.data === base + 32'd3 && s_if.index === 5'd3 &&
            reg_addr === 5'd3)) bad++;
    end
    chk("t2_stall_stable", 64'(bad), 0);
    s_if.ready = 1'b1;
    @(negedge clk);
    chk("t2_advance", 64'(reg_addr), 4);
    chk("t2_valid_drop", 64'(s_if.valid), 0);
    k = 0;
    while (done !== 1'b1 && k < 600) begin
      s_if.ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
    end
    chk("t2_done", 64'(done), 1);
    chk("t2_count", 64'(dump_count), 2);
    check_dump("t2", base, 1);
    s_if.ready = 1'b1;

    // Abort in SEND of index 10, racing a handshake and a start
    base = $urandom;
    pulse_start();
    wait_for(0, 5'd10, 100, "t3_w10", cyc);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("t3_busy", 64'(busy), 0);
    chk("t3_valid", 64'(s_if.valid), 0);
    chk("t3_addr", 64'(reg_addr), 0);
    chk("t3_done", 64'(done), 0);
    chk("t3_count", 64'(dump_count), 2);
    chk("t3_nbeats", 64'(beats.size()), 10);
    beats.delete();
    @(negedge clk);
    chk("t3_done_cnt", 64'(done_cnt), 2);
    pulse_start();
    wait_for(2, 5'd0, 200, "t3b_done", cyc);
    check_dump("t3b", base, 1);
    chk("t3b_count", 64'(dump_count), 3);

    // Start while busy ignored; start in the done cycle honoured
    @(negedge clk);
    base = $urandom;
    pulse_start();
    wait_for(1, 5'd5, 100, "t4_w5", cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(2, 5'd0, 200, "t4_done", cyc);
    start = 1'b1;
    check_dump("t4", base, 1);
    chk("t4_count", 64'(dump_count), 4);
    @(negedge clk);
    start = 1'b0;
    chk("t4_re_busy", 64'(busy), 1);
    chk("t4_re_valid", 64'(s_if.valid), 0);
    @(negedge clk);
    chk("t4_re_lat", 64'(s_if.valid), 1);
    chk("t4_re_idx", 64'(s_if.index), 0);
    wait_for(2, 5'd0, 200, "t4b_done", cyc);
    check_dump("t4b", base, 1);
    chk("t4b_count", 64'(dump_count), 5);

    // Auto mode
    @(negedge clk);
    noop = 1'b1;
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) saw++;
    end
    chk("t5_no_auto", 64'(saw), 0);
    chk("t5_count0", 64'(dump_count), 5);
    auto_en = 1'b1;
    @(negedge clk);
    wait_for(2, 5'd0, 200, "t5_done1", cyc);
    chk("t5_gap_idle", 64'(busy), 0);
    @(negedge clk);
    chk("t5_restart", 64'(busy), 1);
    wait_for(2, 5'd0, 200, "t5_done2", cyc);
    noop = 1'b0; auto_en = 1'b0;
    check_dump("t5", base, 2);
    chk("t5_count", 64'(dump_count), 7);
    @(negedge clk);
    chk("t5_stop", 64'(busy), 0);

    // Single-register build
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("t6_busy", 64'(busy1), 1);
    @(negedge clk);
    chk("t6_valid", 64'(s1_if.valid), 1);
    chk("t6_index", 64'(s1_if.index), 0);
    chk("t6_last", 64'(s1_if.last), 1);
    chk("t6_pc", 64'(s1_if.data), 64'(base1));
    @(negedge clk);
    chk("t6_done", 64'(done1), 1);
    chk("t6_count", 64'(dump_count1), 1);
    chk("t6_idle", 64'(busy1), 0);

    chk("stream_stability", 64'(viol), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
